// File: rtl/ldm_stm_sequencer.sv
// Multi-register LDM/STM/PUSH/POP sequencer: walks a register list low-to-high, does one
// word access per register through register_file and data memory, then optionally writes back the base.
module ldm_stm_sequencer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        dec_before,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  input  logic [31:0] pc_value,
  output logic [3:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [3:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        pc_load_valid,
  output logic [31:0] pc_load_value,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int WDW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_t        state_q, state_d;
  logic [15:0]   list_q, list_d;
  logic          load_q, load_d;
  logic          wb_q, wb_d;
  logic [3:0]    base_q, base_d;
  logic [31:0]   final_q, final_d;
  logic [31:0]   pcst_q, pcst_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic          pcv_q, pcv_d;
  logic [31:0]   pcval_q, pcval_d;
  logic          err_q, err_d;

  logic [4:0]    cnt;
  logic [31:0]   span;
  logic [31:0]   start_addr;
  logic [31:0]   final_addr;
  logic [3:0]    idx;
  logic [15:0]   list_rest;
  logic          accept;
  logic          wait_cyc;
  logic          wd_expire;

  // Address window from the launch-time list size.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, reg_list[i]};
    end
    span       = {25'd0, cnt, 2'b00};
    start_addr = dec_before ? (base_addr - span) : base_addr;
    final_addr = dec_before ? start_addr : (base_addr + span);
  end

  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) idx = 4'(i);
    end
  end

  // Memory handshake: mem_req/mem_addr/mem_we/mem_wdata stay put until the
  // edge where mem_req & mem_ready are both high; that edge completes the transfer.
  assign list_rest = list_q & (list_q - 16'd1);
  assign accept    = req_q & mem_ready;
  assign wait_cyc  = req_q & ~mem_ready;
  assign wd_expire = (MEM_WAIT_MAX != 0) && wait_cyc && (wdog_q == WDW'(MEM_WAIT_MAX));

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    load_d  = load_q;
    wb_d    = wb_q;
    base_d  = base_q;
    final_d = final_q;
    pcst_d  = pcst_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdog_d  = wdog_q;
    pcv_d   = 1'b0;
    pcval_d = pcval_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          list_d  = reg_list;
          load_d  = is_load;
          wb_d    = writeback & ~(is_load & reg_list[base_reg]);
          base_d  = base_reg;
          final_d = final_addr;
          pcst_d  = pc_value;
          wdog_d  = '0;
          if (reg_list != 16'd0) begin
            state_d = S_XFER;
            req_d   = 1'b1;
            we_d    = ~is_load;
            addr_d  = start_addr;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (accept) begin
          list_d = list_rest;
          wdog_d = '0;
          if (load_q && (idx == 4'd15)) begin
            pcv_d   = 1'b1;
            pcval_d = {mem_rdata[31:1], 1'b0};
          end
          if (list_rest != 16'd0) begin
            addr_d = addr_q + 32'd4;
          end else begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = wb_q ? S_WB : S_DONE;
          end
        end else if (wd_expire) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          list_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (wait_cyc && (MEM_WAIT_MAX != 0)) begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      list_q  <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      base_q  <= '0;
      final_q <= '0;
      pcst_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdog_q  <= '0;
      pcv_q   <= 1'b0;
      pcval_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      base_q  <= base_d;
      final_q <= final_d;
      pcst_q  <= pcst_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdog_q  <= wdog_d;
      pcv_q   <= pcv_d;
      pcval_q <= pcval_d;
      err_q   <= err_d;
    end
  end

  // Load data goes straight through so register_file captures it on the accept edge.
  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
    if ((state_q == S_XFER) && accept && load_q && (idx != 4'd15)) begin
      rf_write_en   = 1'b1;
      rf_write_addr = idx;
      rf_write_data = mem_rdata;
    end else if (state_q == S_WB) begin
      rf_write_en   = 1'b1;
      rf_write_addr = base_q;
      rf_write_data = final_q;
    end
  end

  assign rf_read_addr  = idx;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = (req_q && we_q) ? ((idx == 4'd15) ? pcst_q : rf_read_data) : 32'd0;
  assign pc_load_valid = pcv_q;
  assign pc_load_value = pcval_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign bus_err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register_file model, a memory responder
// and queue-based scoreboards for memory accesses, register writes and PC loads.
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        dec_before;
  logic        writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic [31:0] pc_value;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_en;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        pc_load_valid;
  logic [31:0] pc_load_value;
  logic        busy;
  logic        done;
  logic        bus_err;
  logic [1:0]  dbg_state;

  ldm_stm_sequencer #(.MEM_WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .dec_before(dec_before),
    .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .pc_value(pc_value), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_load_valid(pc_load_valid),
    .pc_load_value(pc_load_value), .busy(busy), .done(done), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register_file model and monitors
  logic [31:0] rf_m [16];
  assign rf_read_data = rf_m[rf_read_addr];

  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  logic [31:0] exp_rf_q[$];
  logic [31:0] act_rf_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] act_pc_q[$];
  logic [31:0] rd_q[$];

  int total = 0;
  int bad = 0;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_m[i] <= 32'hC0DE_0000 | 32'(i);
    end else begin
      if (mem_req && mem_ready) begin
        act_q.push_back({31'd0, mem_we});
        act_q.push_back(mem_addr);
        act_q.push_back(mem_we ? mem_wdata : mem_rdata);
        if (!mem_we && rd_q.size() > 0) void'(rd_q.pop_front());
      end
      if (rf_write_en) begin
        act_rf_q.push_back({28'd0, rf_write_addr});
        act_rf_q.push_back(rf_write_data);
        if (rf_write_addr != 4'd15) rf_m[rf_write_addr] <= rf_write_data;
      end
      if (pc_load_valid) act_pc_q.push_back(pc_load_value);
    end
  end

  // ---------------- checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({31'd0, we});
    exp_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic exp_rf(input logic [3:0] a, input logic [31:0] d);
    exp_rf_q.push_back({28'd0, a});
    exp_rf_q.push_back(d);
  endtask

  task automatic sb_flush(input string tag);
    chk({tag, "_mem_n"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_mem%0d", tag, i), act_q[i], exp_q[i]);
    chk({tag, "_rf_n"}, 32'(act_rf_q.size()), 32'(exp_rf_q.size()));
    for (int i = 0; i < exp_rf_q.size() && i < act_rf_q.size(); i++)
      chk($sformatf("%s_rf%0d", tag, i), act_rf_q[i], exp_rf_q[i]);
    chk({tag, "_pc_n"}, 32'(act_pc_q.size()), 32'(exp_pc_q.size()));
    for (int i = 0; i < exp_pc_q.size() && i < act_pc_q.size(); i++)
      chk($sformatf("%s_pc%0d", tag, i), act_pc_q[i], exp_pc_q[i]);
    exp_q.delete();    act_q.delete();
    exp_rf_q.delete(); act_rf_q.delete();
    exp_pc_q.delete(); act_pc_q.delete();
    rd_q.delete();
  endtask

  // ---------------- drivers
  task automatic launch(input logic ld, input logic dec, input logic wb,
                        input logic [3:0] b, input logic [31:0] ba, input logic [15:0] lst);
    is_load    = ld;
    dec_before = dec;
    writeback  = wb;
    base_reg   = b;
    base_addr  = ba;
    reg_list   = lst;
    pc_value   = 32'h0000_8888;
    mem_rdata  = (rd_q.size() > 0) ? rd_q[0] : 32'd0;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    // Launch-time fields are latched; scramble them to prove it.
    is_load    = 1'($urandom_range(0, 1));
    dec_before = 1'($urandom_range(0, 1));
    writeback  = 1'($urandom_range(0, 1));
    base_reg   = 4'($urandom_range(0, 15));
    base_addr  = $urandom;
    reg_list   = 16'($urandom);
    pc_value   = $urandom;
  endtask

  // Cycle 1 is the cycle after the start edge.
  task automatic run(input string tag, input int stall_from, input int stall_len,
                     input int exp_cyc, input logic exp_err);
    int cyc;
    cyc = 1;
    prev_wait = 1'b0;
    while (cyc <= 60) begin
      mem_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      mem_rdata = (rd_q.size() > 0) ? rd_q[0] : 32'd0;
      #1;
      if (prev_wait && mem_req) begin
        chk({tag, "_hold_addr"}, mem_addr, prev_addr);
        chk({tag, "_hold_wdata"}, mem_wdata, prev_wdata);
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (done) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    sb_flush(tag);
  endtask

  // ---------------- stimulus
  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; dec_before = 1'b0; writeback = 1'b0;
    base_reg = '0; base_addr = '0; reg_list = '0; pc_value = '0;
    mem_rdata = '0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_write_en}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_pcv", {31'd0, pc_load_valid}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1 STM r4..r7, increment-after, writeback
    exp_mem(1, 32'h100, 32'hC0DE_0004);
    exp_mem(1, 32'h104, 32'hC0DE_0005);
    exp_mem(1, 32'h108, 32'hC0DE_0006);
    exp_mem(1, 32'h10C, 32'hC0DE_0007);
    exp_rf(4'd1, 32'h110);
    launch(0, 0, 1, 4'd1, 32'h100, 16'h00F0);
    run("t1_stm", 99, 0, 6, 0);

    // T2 PUSH r6,r7,lr onto sp
    exp_mem(1, 32'hFF4, 32'hC0DE_0006);
    exp_mem(1, 32'hFF8, 32'hC0DE_0007);
    exp_mem(1, 32'hFFC, 32'hC0DE_000E);
    exp_rf(4'd13, 32'hFF4);
    launch(0, 1, 1, 4'd13, 32'h1000, 16'h40C0);
    run("t2_push", 99, 0, 5, 0);

    // T3 POP r4,pc
    rd_q.push_back(32'hAA);
    rd_q.push_back(32'h201);
    exp_mem(0, 32'hFF4, 32'hAA);
    exp_mem(0, 32'hFF8, 32'h201);
    exp_rf(4'd4, 32'hAA);
    exp_rf(4'd13, 32'hFFC);
    exp_pc_q.push_back(32'h200);
    launch(1, 0, 1, 4'd13, 32'hFF4, 16'h8010);
    run("t3_pop", 99, 0, 4, 0);

    // T4a LDM with base r2 in list: loaded value wins, no WB cycle
    rd_q.push_back(32'h11);
    rd_q.push_back(32'h22);
    exp_mem(0, 32'h200, 32'h11);
    exp_mem(0, 32'h204, 32'h22);
    exp_rf(4'd1, 32'h11);
    exp_rf(4'd2, 32'h22);
    launch(1, 0, 1, 4'd2, 32'h200, 16'h0006);
    run("t4_ldm_base", 99, 0, 3, 0);

    // T4b STM with base r2 and pc in list: original base value stored
    exp_mem(1, 32'h300, 32'h22);
    exp_mem(1, 32'h304, 32'hC0DE_0003);
    exp_mem(1, 32'h308, 32'h0000_8888);
    exp_rf(4'd2, 32'h30C);
    launch(0, 0, 1, 4'd2, 32'h300, 16'h800C);
    run("t4_stm_base", 99, 0, 5, 0);

    // T5a three-cycle stall on the second access
    exp_mem(1, 32'h4000, 32'hC0DE_0008);
    exp_mem(1, 32'h4004, 32'hC0DE_0009);
    exp_mem(1, 32'h4008, 32'hC0DE_000A);
    exp_mem(1, 32'h400C, 32'hC0DE_000B);
    exp_rf(4'd12, 32'h4010);
    launch(0, 0, 1, 4'd12, 32'h4000, 16'h0F00);
    run("t5_stall3", 2, 3, 9, 0);

    // T5b 17-cycle stall: watchdog abort, no writeback
    launch(0, 0, 1, 4'd5, 32'h500, 16'h0003);
    run("t5_wdog", 1, 1000, 18, 1);

    // T5c 16-cycle stall is still tolerated
    exp_mem(1, 32'h600, 32'hC0DE_0000);
    launch(0, 0, 0, 4'd5, 32'h600, 16'h0001);
    run("t5_wdog_edge", 1, 16, 18, 0);

    // T6a empty list: straight to DONE, no access, no writeback
    launch(0, 0, 1, 4'd3, 32'h700, 16'h0000);
    run("t6_empty", 99, 0, 1, 0);

    // T6b reset in the middle of a stalled transfer
    mem_ready = 1'b0;
    launch(0, 0, 1, 4'd3, 32'h800, 16'h00FF);
    @(posedge clk); #1;
    chk("t6_busy_mid", {31'd0, busy}, 32'd1);
    chk("t6_req_mid", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("t6_rst_rf_we", {31'd0, rf_write_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_after_state", {30'd0, dbg_state}, 32'd0);
    sb_flush("t6_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
